fft_butterfly_r2: RTL and testbench
===================================

Name: fft_butterfly_r2

Overview:
- Radix-2 decimation-in-time butterfly add/subtract stage of the FFT datapath.
- Sits directly downstream of the 18-bit complex multiplier. Consumes operand A and the product P = W·B, and produces X = A+P and Y = A−P.
- Two-stage pipeline with valid/ready flow control, per-stage optional divide-by-2 scaling, saturation, and a sticky overflow flag.
- Carries an address tag alongside the data so the downstream RAM write-back knows where the results go.

Parameters:
- DATA_W, 18, width of each signed real/imag component on input and output
- TAG_W, 10, width of the pass-through address/index tag (1024-point FFT)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept the input beat
- DinAR  in  DATA_W  operand A real, signed
- DinAI  in  DATA_W  operand A imag, signed
- DinPR  in  DATA_W  product W·B real, signed (complex multiplier DoutR)
- DinPI  in  DATA_W  product W·B imag, signed (complex multiplier DoutI)
- in_tag  in  TAG_W  index tag accompanying the beat
- scale_en  in  1  1 = divide results by 2 (sampled with the beat)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- DoutXR, DoutXI  out  DATA_W  X = A+P, real/imag
- DoutYR, DoutYI  out  DATA_W  Y = A−P, real/imag
- out_tag  out  TAG_W  tag of the output beat
- ovf  out  1  sticky overflow: saturation occurred since last clear
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst_n=0 at clk edge):
  - both pipeline valid bits, out_valid and ovf go to 0.
  - All data and tag outputs go to 0.
  - in_ready=1 on the first cycle after reset.
- Handshake:
  - A beat transfers on a cycle where valid and ready are both 1.
  - Stall rule: `advance = !out_valid || out_ready`.
  - in_ready = advance || !s1_valid. This combinational path exists only inside the block; it is not passed through from out_ready.
  - out_valid stays asserted and output data is held stable until accepted.
- Stage 1 (register):
  - sign-extend all operands to DATA_W+1.
  - Compute XR=AR+PR, XI=AI+PI, YR=AR−PR, YI=AI−PI. This is exact, with no overflow possible at DATA_W+1.
  - Register scale_en and tag with the beat.
- Stage 2 (register, output):
  - If scale=1: result = sum >>> 1 (arithmetic). This always fits in DATA_W, so ovf is not set.
  - If scale=0: result = sum clipped to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. [−131072, 131071] at the default width.
  - Any component clipped on an accepted stage-2 load sets ovf.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput is 1 beat/cycle. Up to 2 beats are buffered.
- ovf rules:
  - ovf_clr=1 clears ovf on the next edge.
  - If ovf_clr coincides with a new saturation event, set wins and ovf=1.
- Reset mid-operation drops all in-flight beats. No output is produced for beats accepted before reset.
- Stage 1 holds its contents while stage 2 is stalled. Beats are never dropped or duplicated, and order is preserved.

Optional Feature:
- Macro BFLY_ROUND_EN.
- Defined: when scale=1, result = (sum + 1) >>> 1, i.e. round half toward +inf. The +1 is done at DATA_W+2 bits, then saturated; 131071+131071+1 >>>1 = 131071 still fits.
- Undefined: truncation (floor).
- scale=0 behaviour is identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - DATA_W=18, TAG_W=10
  - constants SAT_MAX=131071, SAT_MIN=−131072
  - a complex-sample struct {re, im}. The complex multiplier and downstream RAM interface use the same struct.
- One natural sub-module: fft_scale_sat. It is combinational and handles one component: (DATA_W+1)-bit in, scale, out DATA_W, sat flag. It is instantiated 4× in stage 2.

Test Plan:
- Basic add/sub: A=(1000,−500), P=(200,300), scale=0, tag=5 → 2 cycles later X=(1200,−200), Y=(800,−800), out_tag=5, ovf=0.
- Saturation: A=(131071,−131072), P=(1,1), scale=0 → X=(131071,−131071), Y=(131070,−131072) clipped, ovf=1. A following clean beat keeps ovf=1. ovf_clr → 0. ovf_clr coinciding with a saturating beat → ovf=1.
- Scaling: scale=1, A=(3,−3), P=(0,0) → truncation build X=(1,−2); BFLY_ROUND_EN build X=(2,−1). A=P=(131071,131071) → X=(131071,131071), ovf=0.
- Backpressure: stream tags 0..7 every cycle, out_ready=0 for cycles 3–5 → in_ready drops once 2 beats are held, output tags appear 0..7 in order with no gaps or repeats, and data is stable during the stall.
- Reset mid-stream: accept tags 1,2, assert rst_n=0 for one cycle → out_valid=0 and ovf=0 after reset, tags 1,2 never appear, and the next input emerges with normal 2-cycle latency.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: widths, saturation limits and complex sample type shared across the FFT datapath
package fft_pkg;
  localparam int DATA_W = 18;
  localparam int TAG_W = 10;
  localparam int SAT_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DATA_W - 1));
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_scale_sat.sv
// fft_scale_sat: one butterfly component, optional halve then clip to DATA_W; macro BFLY_ROUND_EN rounds half up when halving
module fft_scale_sat #(
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic [DATA_W:0]   sum,
  input  logic              scale,
  output logic [DATA_W-1:0] res,
  output logic              sat
);
  logic signed [DATA_W+1:0] e, t;
`ifdef BFLY_ROUND_EN
  assign e = {sum[DATA_W], sum} + {{(DATA_W+1){1'b0}}, scale};
`else
  assign e = {sum[DATA_W], sum};
`endif
  assign t = scale ? e >>> 1 : e;
  // fits in DATA_W exactly when the top three bits agree
  assign sat = !(t[DATA_W+1:DATA_W-1] == '0 || t[DATA_W+1:DATA_W-1] == '1);
  assign res = !sat ? t[DATA_W-1:0] : t[DATA_W+1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
endmodule

// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: radix-2 DIT butterfly X=A+P, Y=A-P, two-stage valid/ready pipeline with scaling and sticky saturation flag
module fft_butterfly_r2 #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int TAG_W = fft_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] DinAR,
  input  logic [DATA_W-1:0] DinAI,
  input  logic [DATA_W-1:0] DinPR,
  input  logic [DATA_W-1:0] DinPI,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              scale_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DoutXR,
  output logic [DATA_W-1:0] DoutXI,
  output logic [DATA_W-1:0] DoutYR,
  output logic [DATA_W-1:0] DoutYI,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ovf,
  input  logic              ovf_clr
);
  logic advance, s1_valid, s1_scale;
  logic [TAG_W-1:0] s1_tag;
  logic [3:0][DATA_W:0] s1_sum;
  logic [3:0][DATA_W-1:0] res;
  logic [3:0] sat;
  logic [DATA_W:0] ar, ai, pr, pi;
  assign ar = {DinAR[DATA_W-1], DinAR};
  assign ai = {DinAI[DATA_W-1], DinAI};
  assign pr = {DinPR[DATA_W-1], DinPR};
  assign pi = {DinPI[DATA_W-1], DinPI};
  assign advance = !out_valid || out_ready;
  assign in_ready = advance || !s1_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_tag <= '0;
      s1_sum <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_scale <= scale_en;
        s1_tag <= in_tag;
        s1_sum <= {ai - pi, ar - pr, ai + pi, ar + pr};
      end
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_ss
    fft_scale_sat #(.DATA_W(DATA_W)) u_ss (
      .sum(s1_sum[i]),
      .scale(s1_scale),
      .res(res[i]),
      .sat(sat[i])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DoutXR <= '0;
      DoutXI <= '0;
      DoutYR <= '0;
      DoutYI <= '0;
      out_tag <= '0;
      ovf <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          DoutXR <= res[0];
          DoutXI <= res[1];
          DoutYR <= res[2];
          DoutYI <= res[3];
          out_tag <= s1_tag;
        end
      end
      // a new saturation event outranks a simultaneous clear
      ovf <= (advance && s1_valid && |sat) || (ovf && !ovf_clr);
    end
  end
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// tb_fft_butterfly_r2: directed self-checking bench for fft_butterfly_r2 (expectations follow BFLY_ROUND_EN when defined)
module tb_fft_butterfly_r2;
  import fft_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, scale_en = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [DATA_W-1:0] DinAR = '0, DinAI = '0, DinPR = '0, DinPI = '0;
  logic [DATA_W-1:0] DoutXR, DoutXI, DoutYR, DoutYI;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fft_butterfly_r2 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .DinAR(DinAR), .DinAI(DinAI), .DinPR(DinPR), .DinPI(DinPI),
    .in_tag(in_tag), .scale_en(scale_en), .out_valid(out_valid), .out_ready(out_ready),
    .DoutXR(DoutXR), .DoutXI(DoutXI), .DoutYR(DoutYR), .DoutYI(DoutYI),
    .out_tag(out_tag), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  task automatic chk(input string name, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input int ar, input int ai, input int pr, input int pi, input logic sc, input int tag);
    DinAR = ar[DATA_W-1:0];
    DinAI = ai[DATA_W-1:0];
    DinPR = pr[DATA_W-1:0];
    DinPI = pi[DATA_W-1:0];
    scale_en = sc;
    in_tag = tag[TAG_W-1:0];
    in_valid = 1'b1;
  endtask
  task automatic run_beat(input string name, input int ar, input int ai, input int pr, input int pi,
                          input logic sc, input int tag, input int exr, input int exi, input int eyr, input int eyi);
    drive(ar, ai, pr, pi, sc, tag);
    tick;
    in_valid = 1'b0;
    chk({name, "_valid_early"}, out_valid, 0);
    tick;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_xr"}, $signed(DoutXR), exr);
    chk({name, "_xi"}, $signed(DoutXI), exi);
    chk({name, "_yr"}, $signed(DoutYR), eyr);
    chk({name, "_yi"}, $signed(DoutYI), eyi);
    chk({name, "_tag"}, out_tag, tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int next_tag, exp_tag, held_tag, held_xr;
    logic held, saw_stall;
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_xr", $signed(DoutXR), 0);
    chk("rst_yi", $signed(DoutYI), 0);
    chk("rst_tag", out_tag, 0);
    run_beat("basic", 1000, -500, 200, 300, 1'b0, 5, 1200, -200, 800, -800);
    chk("basic_ovf", ovf, 0);
    run_beat("sat", SAT_MAX, SAT_MIN, 1, 1, 1'b0, 6, SAT_MAX, -131071, 131070, SAT_MIN);
    chk("sat_ovf", ovf, 1);
    run_beat("clean", 1000, -500, 200, 300, 1'b0, 7, 1200, -200, 800, -800);
    chk("clean_ovf_sticky", ovf, 1);
    drive(SAT_MAX, SAT_MIN, 1, 1, 1'b0, 8);
    tick;
    in_valid = 1'b0;
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("clr_vs_sat_valid", out_valid, 1);
    chk("clr_vs_sat_ovf", ovf, 1);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    chk("clr_ovf", ovf, 0);
`ifdef BFLY_ROUND_EN
    run_beat("scale_small", 3, -3, 0, 0, 1'b1, 10, 2, -1, 2, -1);
    run_beat("scale_neg", SAT_MIN, SAT_MIN, SAT_MIN, SAT_MAX, 1'b1, 12, SAT_MIN, 0, 0, -131071);
`else
    run_beat("scale_small", 3, -3, 0, 0, 1'b1, 10, 1, -2, 1, -2);
    run_beat("scale_neg", SAT_MIN, SAT_MIN, SAT_MIN, SAT_MAX, 1'b1, 12, SAT_MIN, -1, 0, SAT_MIN);
`endif
    run_beat("scale_max", SAT_MAX, SAT_MAX, SAT_MAX, SAT_MAX, 1'b1, 11, SAT_MAX, SAT_MAX, 0, 0);
    chk("scale_ovf", ovf, 0);
    next_tag = 0;
    exp_tag = 0;
    held = 1'b0;
    saw_stall = 1'b0;
    held_tag = 0;
    held_xr = 0;
    tick;
    for (int c = 0; c < 60 && exp_tag < 8; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (next_tag < 8) drive(100 * next_tag, -next_tag, next_tag, 2 * next_tag, 1'b0, next_tag);
      else in_valid = 1'b0;
      #1;
      if (held) begin
        chk("bp_hold_tag", out_tag, held_tag);
        chk("bp_hold_xr", $signed(DoutXR), held_xr);
      end
      held = out_valid && !out_ready;
      held_tag = int'(out_tag);
      held_xr = int'($signed(DoutXR));
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp_tag", out_tag, exp_tag);
        chk("bp_xr", $signed(DoutXR), 101 * exp_tag);
        chk("bp_yi", $signed(DoutYI), -3 * exp_tag);
        exp_tag++;
      end
      if (in_valid && in_ready) next_tag++;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", exp_tag, 8);
    chk("bp_stall_seen", saw_stall, 1);
    tick;
    out_ready = 1'b0;
    drive(SAT_MAX, SAT_MIN, 1, 1, 1'b0, 1);
    tick;
    drive(1000, -500, 200, 300, 1'b0, 2);
    tick;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_ovf", ovf, 1);
    chk("pre_rst_in_ready", in_ready, 0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_tag", out_tag, 0);
    run_beat("post_rst", 1000, -500, 200, 300, 1'b0, 9, 1200, -200, 800, -800);
    tick;
    chk("post_rst_drain", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
